// File: rtl/mmio_pkg.sv
// mmio_pkg: IO region offsets, status bit positions and poller states shared by mmio_frame_sync
package mmio_pkg;
   localparam logic [11:0] CTRL_BASE   = 12'h000;
   localparam logic [11:0] PVGA_BASE   = 12'h040;
   localparam logic [11:0] STAGE_BASE  = 12'h080;
   localparam logic [11:0] STATUS_ADDR = 12'h0C0;
   localparam logic [11:0] FRAME_ADDR  = 12'h0C1;
   localparam int STAT_PENDING = 0;
   localparam int STAT_FLAG    = 1;
   typedef enum logic [2:0] {IDLE, LATCH, SAMPLE, CLK_LO, CLK_HI, DONE} poll_state_e;
endpackage

// File: rtl/controller_poller.sv
// controller_poller: serial SNES-style poller; latches all controllers, shifts CTRL_BITS bits, commits atomically
module controller_poller import mmio_pkg::*; #(
   parameter int NUM_PLAYERS = 2,
   parameter int CTRL_BITS   = 16,
   parameter int HALF        = 300
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             start,
   input  logic [NUM_PLAYERS-1:0]           ctrl_data,
   output logic                             ctrl_latch,
   output logic                             ctrl_clk,
   output logic [NUM_PLAYERS*CTRL_BITS-1:0] ctrl_state
);
   localparam int CW = $clog2(2*HALF+1);
   localparam int IW = CTRL_BITS > 1 ? $clog2(CTRL_BITS) : 1;
   poll_state_e state, state_n;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [NUM_PLAYERS-1:0][CTRL_BITS-1:0] shadow;
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shadow     <= '0;
         ctrl_state <= '0;
      end else begin
         state <= state_n;
         cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
         if (state == LATCH) idx <= '0;
         if (state == CLK_HI && state_n == SAMPLE) idx <= idx + 1'b1;
         if (state == SAMPLE)
            for (int p = 0; p < NUM_PLAYERS; p++) shadow[p][idx] <= ~ctrl_data[p];
         if (state == DONE) ctrl_state <= shadow;
      end
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start ? LATCH : IDLE;
         LATCH:   state_n = (cnt == CW'(2*HALF-1)) ? SAMPLE : LATCH;
         SAMPLE:  state_n = (idx == IW'(CTRL_BITS-1)) ? DONE : CLK_LO;
         CLK_LO:  state_n = (cnt == CW'(HALF-1)) ? CLK_HI : CLK_LO;
         CLK_HI:  state_n = (cnt == CW'(HALF-1)) ? SAMPLE : CLK_HI;
         default: state_n = IDLE;
      endcase
   end
   always_comb begin
      ctrl_latch = state == LATCH;
      ctrl_clk   = state != CLK_LO;
   end
endmodule

// File: rtl/mmio_frame_sync.sv
// mmio_frame_sync: RAM/IO decode, double-buffered VGA descriptors committed on vsync, frame counter
module mmio_frame_sync import mmio_pkg::*; #(
   parameter int NUM_PLAYERS = 2,
   parameter int CTRL_BITS   = 16,
   parameter int HALF        = 300,
   parameter int VGA_W       = 64
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [12:0]                  address,
   input  logic [31:0]                  data_in,
   input  logic                         wren,
   output logic [31:0]                  data_out,
   output logic                         ram_wren,
   input  logic [31:0]                  ram_q,
   input  logic                         vga_vs,
   output logic                         ctrl_latch,
   output logic                         ctrl_clk,
   input  logic [NUM_PLAYERS-1:0]       ctrl_data,
   output logic [NUM_PLAYERS*VGA_W-1:0] p_vga,
   output logic [VGA_W-1:0]             stage_vga
);
   logic [11:0] addr;
   logic io_sel, io_sel_q, io_wr, stat_wr, vsync_rise, commit;
   logic pending, flag, vs1, vs2, vs3;
   logic [31:0] io_rd, io_rd_q, frame_cnt;
   logic [NUM_PLAYERS-1:0][VGA_W-1:0] p_shadow;
   logic [VGA_W-1:0] s_shadow;
   logic [NUM_PLAYERS*CTRL_BITS-1:0] ctrl_state;
   assign addr       = address[11:0];
   assign io_sel     = address[12];
   assign io_wr      = wren & io_sel;
   assign ram_wren   = wren & ~io_sel;
   assign stat_wr    = io_wr && addr == STATUS_ADDR;
   assign vsync_rise = vs2 & ~vs3;
   assign commit     = vsync_rise & (pending | (stat_wr & data_in[STAT_PENDING]));
   assign data_out   = io_sel_q ? io_rd_q : ram_q;
   controller_poller #(.NUM_PLAYERS(NUM_PLAYERS), .CTRL_BITS(CTRL_BITS), .HALF(HALF)) u_poller (
      .clock(clock), .reset(reset), .start(vsync_rise), .ctrl_data(ctrl_data),
      .ctrl_latch(ctrl_latch), .ctrl_clk(ctrl_clk), .ctrl_state(ctrl_state)
   );
   always_comb begin
      io_rd = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (addr == CTRL_BASE + 12'(p)) io_rd = 32'(ctrl_state[p*CTRL_BITS +: CTRL_BITS]);
         if (addr == PVGA_BASE + 12'(2*p)) io_rd = p_shadow[p][31:0];
         if (addr == PVGA_BASE + 12'(2*p+1)) io_rd = 32'(p_shadow[p] >> 32);
      end
      if (addr == STAGE_BASE) io_rd = s_shadow[31:0];
      if (addr == STAGE_BASE + 12'd1) io_rd = 32'(s_shadow >> 32);
      if (addr == STATUS_ADDR) io_rd = 32'({flag, pending});
      if (addr == FRAME_ADDR) io_rd = frame_cnt;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         {vs1, vs2, vs3} <= '0;
         io_sel_q  <= 1'b1;
         io_rd_q   <= '0;
         p_shadow  <= '0;
         s_shadow  <= '0;
         p_vga     <= '0;
         stage_vga <= '0;
         pending   <= 1'b0;
         flag      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         {vs1, vs2, vs3} <= {vga_vs, vs1, vs2};
         io_sel_q <= io_sel;
         io_rd_q  <= io_rd;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (io_wr && addr == PVGA_BASE + 12'(2*p)) p_shadow[p][31:0] <= data_in;
            if (io_wr && addr == PVGA_BASE + 12'(2*p+1)) p_shadow[p][VGA_W-1:32] <= data_in[VGA_W-33:0];
         end
         if (io_wr && addr == STAGE_BASE) s_shadow[31:0] <= data_in;
         if (io_wr && addr == STAGE_BASE + 12'd1) s_shadow[VGA_W-1:32] <= data_in[VGA_W-33:0];
         // shadows copy their pre-edge value, so a same-cycle shadow write waits for the next commit
         if (commit) begin
            p_vga     <= p_shadow;
            stage_vga <= s_shadow;
         end
         pending   <= commit ? 1'b0 : (stat_wr && data_in[STAT_PENDING]) ? 1'b1 : pending;
         flag      <= vsync_rise | (flag & ~(stat_wr & data_in[STAT_FLAG]));
         frame_cnt <= frame_cnt + 32'(vsync_rise);
      end
   end
endmodule

// File: tb/tb_mmio_frame_sync.sv
// tb_mmio_frame_sync: scoreboarded reads plus per-feature checks of decode, commit, poller and frame logic
module tb_mmio_frame_sync;
   localparam int NP = 4, CB = 16, HALF = 2, VW = 64;
   logic clock = 0, reset = 1, wren = 0, vga_vs = 0, press = 0;
   logic ram_wren, ctrl_latch, ctrl_clk;
   logic [12:0] address = '0;
   logic [31:0] data_in = '0, data_out, ram_q;
   logic [NP-1:0] ctrl_data = '1;
   logic [NP*VW-1:0] p_vga;
   logic [VW-1:0] stage_vga;
   logic [31:0] mem [64];
   typedef struct {logic [31:0] exp; int due; string name;} exp_t;
   exp_t sb[$];
   int n_tests, n_fail, cyc, bitn, n_lo, bad_lo, lo_start, lat_cyc;

   mmio_frame_sync #(.NUM_PLAYERS(NP), .CTRL_BITS(CB), .HALF(HALF), .VGA_W(VW)) dut (
      .clock(clock), .reset(reset), .address(address), .data_in(data_in), .wren(wren),
      .data_out(data_out), .ram_wren(ram_wren), .ram_q(ram_q), .vga_vs(vga_vs),
      .ctrl_latch(ctrl_latch), .ctrl_clk(ctrl_clk), .ctrl_data(ctrl_data),
      .p_vga(p_vga), .stage_vga(stage_vga)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc++;
      if (ctrl_latch) lat_cyc++;
   end

   // external RAM with 1-cycle read latency
   always @(posedge clock) begin
      if (ram_wren) mem[address[5:0]] <= data_in;
      ram_q <= mem[address[5:0]];
   end

   // controller model: bit index advances on each rising ctrl_clk after the latch
   always @(posedge ctrl_clk or posedge ctrl_latch) begin
      bitn = ctrl_latch ? 0 : bitn + 1;
      ctrl_data = (press && bitn == 3) ? 4'b1101 : 4'b1111;
   end

   always @(negedge ctrl_clk) lo_start = cyc;
   always @(posedge ctrl_clk) begin
      n_lo++;
      if (cyc - lo_start != HALF) bad_lo++;
   end

   always @(negedge clock) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         n_tests++;
         if (data_out !== e.exp) begin
            n_fail++;
            $display("FAIL %s: data_out=%h expected %h", e.name, data_out, e.exp);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clock);
   endtask

   task automatic rd(input logic [12:0] a, input logic [31:0] e, input string nm);
      address = a;
      wren = 0;
      sb.push_back('{e, cyc + 1, nm});
      tick();
   endtask

   task automatic wr(input logic [12:0] a, input logic [31:0] d);
      address = a;
      data_in = d;
      wren = 1;
      tick();
      wren = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      tick(3);
      n_tests++;
      if (data_out !== 32'h0 || p_vga !== '0 || stage_vga !== '0) begin
         n_fail++;
         $display("FAIL reset_outs: data_out=%h p_vga=%h stage=%h expected zeros", data_out, p_vga, stage_vga);
      end
      n_tests++;
      if (ctrl_latch !== 1'b0 || ctrl_clk !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ctrl: latch=%b clk=%b expected 0/1", ctrl_latch, ctrl_clk);
      end
      reset = 0;
      rd(13'h10C0, 32'h0, "reset_status");
      rd(13'h10C1, 32'h0, "reset_frame");
      rd(13'h1001, 32'h0, "reset_ctrl1");
   endtask

   task automatic test_ram();
      address = 13'h0005;
      data_in = 32'hDEADBEEF;
      wren = 1;
      #1;
      n_tests++;
      if (ram_wren !== 1'b1) begin
         n_fail++;
         $display("FAIL ram_wren_ram: got %b expected 1", ram_wren);
      end
      tick();
      address = 13'h1FFF;
      data_in = 32'hFFFFFFFF;
      #1;
      n_tests++;
      if (ram_wren !== 1'b0) begin
         n_fail++;
         $display("FAIL ram_wren_io: got %b expected 0", ram_wren);
      end
      tick();
      wr(13'h0006, 32'h01234567);
      wr(13'h0007, 32'h89ABCDEF);
      rd(13'h0005, 32'hDEADBEEF, "ram_rd5");
      rd(13'h1FFF, 32'h0, "io_unmapped_1fff");
      rd(13'h0006, 32'h01234567, "ram_rd6");
      rd(13'h0007, 32'h89ABCDEF, "ram_rd7");
      rd(13'h003F, 32'h5A00003F, "ram_rd3f_untouched");
   endtask

   task automatic test_commit();
      wr(13'h1046, 32'h11111111);
      wr(13'h1047, 32'h22222222);
      wr(13'h1080, 32'h12345678);
      wr(13'h1048, 32'hFFFFFFFF);
      wr(13'h10C0, 32'h1);
      rd(13'h10C0, 32'h1, "status_pending");
      rd(13'h1046, 32'h11111111, "shadow_p3_lo");
      rd(13'h1047, 32'h22222222, "shadow_p3_hi");
      rd(13'h1048, 32'h0, "unmapped_p4");
      rd(13'h1004, 32'h0, "unmapped_ctrl4");
      vga_vs = 1;
      tick(2);
      n_tests++;
      if (p_vga[3*VW +: VW] !== 64'h0) begin
         n_fail++;
         $display("FAIL p3_before_vsync: got %h expected 0", p_vga[3*VW +: VW]);
      end
      tick();
      n_tests++;
      if (p_vga[3*VW +: VW] !== 64'h2222222211111111) begin
         n_fail++;
         $display("FAIL p3_commit: got %h expected 2222222211111111", p_vga[3*VW +: VW]);
      end
      n_tests++;
      if (stage_vga !== 64'h12345678 || p_vga[0 +: VW] !== 64'h0) begin
         n_fail++;
         $display("FAIL stage_commit: stage=%h p0=%h expected 12345678/0", stage_vga, p_vga[0 +: VW]);
      end
      vga_vs = 0;
      rd(13'h10C0, 32'h2, "status_after_commit");
      tick(2);
   endtask

   task automatic test_collision();
      wr(13'h10C0, 32'h1);
      vga_vs = 1;
      tick(2);
      address = 13'h1080;
      data_in = 32'h0000AAAA;
      wren = 1;
      tick();
      wren = 0;
      n_tests++;
      if (stage_vga !== 64'h12345678) begin
         n_fail++;
         $display("FAIL collide_old: stage=%h expected 12345678", stage_vga);
      end
      vga_vs = 0;
      tick(3);
      wr(13'h10C0, 32'h1);
      vga_vs = 1;
      tick(3);
      n_tests++;
      if (stage_vga !== 64'h0000AAAA) begin
         n_fail++;
         $display("FAIL collide_next: stage=%h expected 0000aaaa", stage_vga);
      end
      vga_vs = 0;
      tick(2);
   endtask

   task automatic test_poller();
      tick(100);
      wr(13'h1080, 32'h00005555);
      press = 1;
      n_lo = 0;
      bad_lo = 0;
      lat_cyc = 0;
      vga_vs = 1;
      tick(4);
      vga_vs = 0;
      tick(100);
      n_tests++;
      if (n_lo != CB - 1 || bad_lo != 0) begin
         n_fail++;
         $display("FAIL clk_pulses: count=%0d bad=%0d expected %0d/0", n_lo, bad_lo, CB - 1);
      end
      n_tests++;
      if (lat_cyc != 2 * HALF) begin
         n_fail++;
         $display("FAIL latch_len: got %0d expected %0d", lat_cyc, 2 * HALF);
      end
      n_tests++;
      if (stage_vga !== 64'h0000AAAA) begin
         n_fail++;
         $display("FAIL no_pending_hold: stage=%h expected 0000aaaa", stage_vga);
      end
      rd(13'h1001, 32'h0008, "poll_p1");
      rd(13'h1000, 32'h0, "poll_p0");
      rd(13'h1003, 32'h0, "poll_p3");
      press = 0;
   endtask

   task automatic test_reset_midpoll();
      press = 1;
      vga_vs = 1;
      tick(3);
      vga_vs = 0;
      tick(20);
      reset = 1;
      tick(2);
      n_tests++;
      if (ctrl_latch !== 1'b0 || ctrl_clk !== 1'b1 || data_out !== 32'h0) begin
         n_fail++;
         $display("FAIL midpoll_reset_ctrl: latch=%b clk=%b data_out=%h expected 0/1/0", ctrl_latch, ctrl_clk, data_out);
      end
      n_tests++;
      if (p_vga !== '0 || stage_vga !== '0) begin
         n_fail++;
         $display("FAIL midpoll_reset_vga: p_vga=%h stage=%h expected zeros", p_vga, stage_vga);
      end
      reset = 0;
      tick(100);
      rd(13'h1001, 32'h0, "midpoll_ctrl1");
      rd(13'h10C1, 32'h0, "midpoll_frame");
      press = 0;
   endtask

   task automatic test_frame();
      for (int i = 0; i < 5; i++) begin
         vga_vs = 1;
         tick(3);
         vga_vs = 0;
         tick(3);
      end
      rd(13'h10C1, 32'd5, "frame_5");
      rd(13'h10C0, 32'h2, "flag_set");
      wr(13'h10C0, 32'h2);
      rd(13'h10C0, 32'h0, "flag_clear");
      vga_vs = 1;
      tick(2);
      wr(13'h10C0, 32'h2);
      vga_vs = 0;
      tick(2);
      rd(13'h10C0, 32'h2, "flag_set_wins");
      rd(13'h10C1, 32'd6, "frame_6");
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h5A000000 | i;
      test_reset();
      test_ram();
      test_commit();
      test_collision();
      test_poller();
      test_reset_midpoll();
      test_frame();
      tick(3);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d reads left expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
